// File: rtl/dmem_store_bridge_pkg.sv
// Shared types and constants for the data-memory store bridge.
package dmem_pkg;

  // Bridge controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no memory transaction outstanding
    DRAIN = 2'd1,  // buffered store being written to memory
    LOAD  = 2'd2,  // load miss read outstanding
    LDONE = 2'd3   // read data latched, handed to the pipe this cycle
  } state_e;

  localparam int SB_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;

  // Byte-offset bits below the word address; matching uses [ADDR_W-1:WORD_LSB].
  localparam int WORD_LSB = 2;

endpackage

// File: rtl/dmem_store_bridge_if.sv
// Data-memory request bus between the bridge (master) and the memory (slave).
// Handshake: master raises dm_req with dm_we/dm_addr/dm_wdata and holds all of
// them stable until the slave answers with a one-cycle dm_ack; dm_ack is only
// legal while dm_req is high, and dm_rdata is valid in the dm_ack cycle of a read.
interface dmem_store_bridge_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );

endinterface

// File: rtl/dmem_store_bridge_store_buffer.sv
// Circular store buffer with a parallel youngest-entry word-address search.
module store_buffer
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic [ADDR_W-WORD_LSB-1:0] search_word,
  output logic                       hit,
  output logic [DATA_W-1:0]          hit_data,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [ADDR_W-1:0] addr_d [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [DATA_W-1:0] data_d [SB_DEPTH];

  // Pointer, count and storage update; a push into a full buffer is only
  // issued alongside a pop, so the write lands in the slot being freed.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Search oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[idx][ADDR_W-1:WORD_LSB] == search_word)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign full      = (count_q == CNT_W'(SB_DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/dmem_store_bridge.sv
// MEM-stage bridge: stores retire into a store buffer, loads forward from it or
// stall while a read goes to the multi-cycle data memory.
module dmem_store_bridge
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                stall,
  output logic                sb_empty,
  dmem_store_bridge_if.master dm,
  output state_e              dbg_state
);

  state_e            state_q, state_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d, rdata_q, rdata_d;

  logic              sb_hit, sb_full, sb_empty_buf, sb_push, sb_pop;
  logic              is_load, load_miss;
  logic [DATA_W-1:0] sb_hit_data, sb_head_data;
  logic [ADDR_W-1:0] sb_head_addr;

  // A simultaneous read and write is treated as a write.
  assign is_load   = mem_read && !mem_write;
  assign load_miss = is_load && !sb_hit;
  assign sb_pop    = (state_q == DRAIN) && dm.dm_ack;
  // The pipe only presents new stores while no load is in flight.
  assign sb_push   = ((state_q == IDLE) || (state_q == DRAIN)) &&
                     mem_write && (!sb_full || sb_pop);

  store_buffer #(
    .SB_DEPTH(SB_DEPTH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_addr  (adr),
    .push_data  (wdata),
    .pop        (sb_pop),
    .search_word(adr[ADDR_W-1:WORD_LSB]),
    .hit        (sb_hit),
    .hit_data   (sb_hit_data),
    .head_addr  (sb_head_addr),
    .head_data  (sb_head_data),
    .full       (sb_full),
    .empty      (sb_empty_buf)
  );

  // Next state, memory request registers, stall and load-data selection.
  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    rdata_d    = rdata_q;
    rdata      = sb_hit_data;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = (mem_write && sb_full) || load_miss;
        if (load_miss) begin
          state_d   = LOAD;
          dm_req_d  = 1'b1;
          dm_we_d   = 1'b0;
          dm_addr_d = adr;
        end else if (!sb_empty_buf) begin
          state_d    = DRAIN;
          dm_req_d   = 1'b1;
          dm_we_d    = 1'b1;
          dm_addr_d  = sb_head_addr;
          dm_wdata_d = sb_head_data;
        end
      end
      DRAIN: begin
        stall = (mem_write && sb_full && !sb_pop) || load_miss;
        if (dm.dm_ack) begin
          // A waiting load miss goes out right after the write completes,
          // ahead of any further drains.
          if (load_miss) begin
            state_d   = LOAD;
            dm_req_d  = 1'b1;
            dm_we_d   = 1'b0;
            dm_addr_d = adr;
          end else begin
            state_d  = IDLE;
            dm_req_d = 1'b0;
          end
        end
      end
      LOAD: begin
        stall = 1'b1;
        if (dm.dm_ack) begin
          state_d  = LDONE;
          dm_req_d = 1'b0;
          rdata_d  = dm.dm_rdata;
        end
      end
      LDONE: begin
        rdata   = rdata_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and memory-interface registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign sb_empty    = sb_empty_buf && (state_q != DRAIN);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_store_bridge.sv
// Directed bench for dmem_store_bridge: forwarding, load misses, full buffer,
// load-behind-write ordering and reset mid-transaction.
module tb_dmem_store_bridge;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] adr, wdata, rdata;
  logic        stall, sb_empty;
  state_e      dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_cnt;
  logic [63:0] exp_q[$];
  logic [63:0] sb_e;

  dmem_store_bridge_if dm_if ();

  dmem_store_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .adr      (adr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .sb_empty (sb_empty),
    .dm       (dm_if),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every acknowledged memory write must be the oldest store issued.
  always @(negedge clk) begin
    if (!rst && dm_if.dm_req && dm_if.dm_ack && dm_if.dm_we) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_wr_addr", dm_if.dm_addr, sb_e[63:32]);
        check("sb_wr_data", dm_if.dm_wdata, sb_e[31:0]);
      end
    end
  end

  // Protocol rule: the pipe never presents a load and a store together.
  always @(posedge clk) begin
    if (!rst) assert (!(mem_read && mem_write)) else $error("mem_read and mem_write both high");
  end

  // Driver tasks: a cycle starts 1 unit after the rising edge; checks run at +3.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    adr       = '0;
    wdata     = '0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    adr       = a;
    wdata     = d;
    exp_q.push_back({a, d});
  endtask

  task automatic lw(input logic [31:0] a);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    adr       = a;
  endtask

  // Acknowledge writes until the buffer reports empty; bounded.
  task automatic drain_all();
    int n;
    n = 0;
    while (!sb_empty && n < 60) begin
      dm_if.dm_ack = dm_if.dm_req && dm_if.dm_we;
      tick();
      dm_if.dm_ack = 1'b0;
      n++;
    end
    settle();
    check("drain_sb_empty", 32'(sb_empty), 32'd1);
    check("drain_req_low", 32'(dm_if.dm_req), 32'd0);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    dm_if.dm_ack   = 1'b0;
    dm_if.dm_rdata = '0;
    idle_in();
    repeat (2) tick();
    rst = 1'b0;
    settle();
    check("rst_dm_req", 32'(dm_if.dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_if.dm_we), 32'd0);
    check("rst_dm_addr", dm_if.dm_addr, 32'd0);
    check("rst_dm_wdata", dm_if.dm_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sb_empty", 32'(sb_empty), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // 1: store then load of the same word forwards with no memory ack.
    sw(32'h10, 32'hAAAA_0001);
    settle();
    check("t1_sw_stall", 32'(stall), 32'd0);
    tick();
    lw(32'h10);
    settle();
    check("t1_hit_stall", 32'(stall), 32'd0);
    check("t1_hit_rdata", rdata, 32'hAAAA_0001);
    tick();
    lw(32'h12);
    settle();
    check("t1_drain_state", 32'(dbg_state), 32'(DRAIN));
    check("t1_drain_req", 32'(dm_if.dm_req), 32'd1);
    check("t1_drain_we", 32'(dm_if.dm_we), 32'd1);
    check("t1_drain_addr", dm_if.dm_addr, 32'h10);
    check("t1_head_hit_stall", 32'(stall), 32'd0);
    check("t1_head_hit_rdata", rdata, 32'hAAAA_0001);
    check("t1_sb_not_empty", 32'(sb_empty), 32'd0);
    tick();
    idle_in();
    drain_all();

    // 2: two stores to one word; the load sees the younger, drain keeps order.
    sw(32'h10, 32'h1);
    settle();
    tick();
    sw(32'h10, 32'h2);
    settle();
    tick();
    lw(32'h10);
    settle();
    check("t2_young_stall", 32'(stall), 32'd0);
    check("t2_young_rdata", rdata, 32'h2);
    tick();
    idle_in();
    drain_all();

    // 3: load miss, ack 3 cycles after the request: 5 stall cycles.
    lw(32'h40);
    stall_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      dm_if.dm_ack   = (c == 4);
      dm_if.dm_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      settle();
      if (c == 1) begin
        check("t3_rd_req", 32'(dm_if.dm_req), 32'd1);
        check("t3_rd_we", 32'(dm_if.dm_we), 32'd0);
        check("t3_rd_addr", dm_if.dm_addr, 32'h40);
      end
      if (stall) stall_cnt++;
      tick();
    end
    dm_if.dm_ack = 1'b0;
    settle();
    check("t3_stall_cycles", 32'(stall_cnt), 32'd5);
    check("t3_ldone_stall", 32'(stall), 32'd0);
    check("t3_ldone_rdata", rdata, 32'hDEAD_BEEF);
    check("t3_ldone_state", 32'(dbg_state), 32'(LDONE));
    tick();
    idle_in();
    settle();
    check("t3_back_idle", 32'(dbg_state), 32'(IDLE));
    check("t3_req_low", 32'(dm_if.dm_req), 32'd0);
    tick();

    // 4: five stores into a 4-deep buffer with ack held low.
    for (int i = 0; i < 4; i++) begin
      sw(32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1));
      settle();
      check("t4_sw_no_stall", 32'(stall), 32'd0);
      tick();
    end
    sw(32'h110, 32'h55);
    settle();
    check("t4_full_stall", 32'(stall), 32'd1);
    tick();
    settle();
    check("t4_full_stall_hold", 32'(stall), 32'd1);
    check("t4_head_addr", dm_if.dm_addr, 32'h100);
    tick();
    dm_if.dm_ack = 1'b1;
    settle();
    check("t4_pop_push_stall", 32'(stall), 32'd0);
    tick();
    dm_if.dm_ack = 1'b0;
    idle_in();
    drain_all();

    // 5: load miss behind an outstanding write.
    sw(32'h200, 32'h77);
    settle();
    tick();
    idle_in();
    settle();
    tick();
    lw(32'h300);
    settle();
    check("t5_miss_stall", 32'(stall), 32'd1);
    check("t5_wr_we", 32'(dm_if.dm_we), 32'd1);
    check("t5_wr_addr", dm_if.dm_addr, 32'h200);
    tick();
    settle();
    check("t5_wr_we_stable", 32'(dm_if.dm_we), 32'd1);
    check("t5_wr_addr_stable", dm_if.dm_addr, 32'h200);
    check("t5_wr_data_stable", dm_if.dm_wdata, 32'h77);
    tick();
    dm_if.dm_ack = 1'b1;
    settle();
    check("t5_ack_stall", 32'(stall), 32'd1);
    tick();
    dm_if.dm_ack = 1'b0;
    settle();
    check("t5_rd_state", 32'(dbg_state), 32'(LOAD));
    check("t5_rd_req", 32'(dm_if.dm_req), 32'd1);
    check("t5_rd_we", 32'(dm_if.dm_we), 32'd0);
    check("t5_rd_addr", dm_if.dm_addr, 32'h300);
    tick();
    dm_if.dm_ack   = 1'b1;
    dm_if.dm_rdata = 32'h1234_5678;
    settle();
    tick();
    dm_if.dm_ack = 1'b0;
    settle();
    check("t5_ldone_stall", 32'(stall), 32'd0);
    check("t5_ldone_rdata", rdata, 32'h1234_5678);
    tick();
    idle_in();
    settle();
    check("t5_sb_empty", 32'(sb_empty), 32'd1);
    tick();

    // 6: reset while a read is outstanding with two stores still buffered.
    sw(32'h500, 32'h1);
    settle();
    tick();
    sw(32'h504, 32'h2);
    settle();
    tick();
    sw(32'h508, 32'h3);
    settle();
    tick();
    lw(32'h600);
    settle();
    tick();
    dm_if.dm_ack = 1'b1;
    settle();
    tick();
    dm_if.dm_ack = 1'b0;
    settle();
    check("t6_pre_state", 32'(dbg_state), 32'(LOAD));
    check("t6_pre_sb_empty", 32'(sb_empty), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    idle_in();
    settle();
    check("t6_dm_req", 32'(dm_if.dm_req), 32'd0);
    check("t6_sb_empty", 32'(sb_empty), 32'd1);
    check("t6_stall", 32'(stall), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    tick();

    // Report.
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
